// File: rtl/axi_gather_w.sv
`default_nettype none
// ============================================================================
//  Module      : axi_gather_w
//  Description : Write-gathering bridge. Narrow single-beat AXI writes from a
//                slave port are merged into a one-line buffer (with per-byte
//                valid bits). The line is written out as one INCR burst on a
//                wide AXI master port on a miss, when the line fills, on an
//                explicit flush request, or after an idle timeout.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                flush           - request write-out of the current line
//                busy            - state is not IDLE
//                err             - sticky: a master write response was not OKAY
//                s_axi_aw*/w*/b* - slave write address/data/response channels
//                m_axi_aw*/w*/b* - master write address/data/response channels
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_gather_w #(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ADDR_WIDTH = 48,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 256,
    parameter int IDLE_TIMEOUT       = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    output logic                              busy,
    output logic                              err,
    // slave write side
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    // master write side
    output logic [0:0]                        m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awlock,
    output logic [3:0]                        m_axi_awcache,
    output logic [2:0]                        m_axi_awprot,
    output logic [3:0]                        m_axi_awqos,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);

    localparam int ADDR_W     = C_M_AXI_ADDR_WIDTH;
    localparam int S_DW       = C_S_AXI_DATA_WIDTH;
    localparam int M_DW       = C_M_AXI_DATA_WIDTH;
    localparam int BL         = C_M_AXI_BURST_LEN;
    localparam int S_BYTES    = S_DW / 8;
    localparam int M_BYTES    = M_DW / 8;
    localparam int LINE_BYTES = BL * M_BYTES;
    localparam int LINE_LG    = $clog2(LINE_BYTES);
    localparam int S_LG       = $clog2(S_BYTES);
    localparam int NWORDS     = LINE_BYTES / S_BYTES;
    localparam int WIDX       = $clog2(NWORDS);
    localparam int WPB        = M_DW / S_DW;
    localparam int BEAT_W     = (BL > 1) ? $clog2(BL) : 1;
    localparam int CNT_W      = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        AW   = 3'd2,
        W    = 3'd3,
        B    = 3'd4
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [ADDR_W-1:0]               base;
    logic [NWORDS-1:0][S_DW-1:0]     line_data;
    logic [NWORDS-1:0][S_BYTES-1:0]  line_valid;
    logic [BEAT_W-1:0]               beat;
    logic [CNT_W-1:0]                idle_cnt;
    logic                            bvalid_q;
    logic                            err_q;

    logic                            both_valid;
    logic                            hit;
    logic                            accept;
    logic                            line_full;
    logic                            timeout;
    logic                            last_beat;
    logic [WIDX-1:0]                 word_idx;
    logic [WIDX-1:0]                 beat_word;
    logic                            unused_low_addr;

    // Byte-lane bits inside a slave word carry no information: strobes do.
    assign unused_low_addr = ^s_axi_awaddr[S_LG-1:0];

    assign both_valid = s_axi_awvalid & s_axi_wvalid;
    assign hit        = (s_axi_awaddr[ADDR_W-1:LINE_LG] == base[ADDR_W-1:LINE_LG]);
    assign word_idx   = s_axi_awaddr[LINE_LG-1:S_LG];
    assign line_full  = &line_valid;
    assign timeout    = (idle_cnt >= CNT_W'(IDLE_TIMEOUT));
    assign last_beat  = (beat == BEAT_W'(BL - 1));
    assign beat_word  = WIDX'(beat) * WIDX'(WPB);

    // Joint address/data handshake. Held off while a slave response is still
    // outstanding so that every accept has its own B beat. In FILL only
    // writes to the open line are taken; a miss waits until the line drains.
    assign accept = both_valid && !bvalid_q &&
                    ((state == IDLE) || ((state == FILL) && hit));

    // ------------------------------------------------------------------
    // Next-state and master-side handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = FILL;
            end
            FILL: begin
                // All triggers fold into one transition, so coincident
                // conditions still produce a single burst.
                if ((both_valid && !hit) || line_full || flush || timeout)
                    state_next = AW;
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_next = W;
            end
            W: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && last_beat) state_next = B;
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_valid <= '0;
            beat       <= '0;
            idle_cnt   <= '0;
            bvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;

            if ((state == B) && m_axi_bvalid) begin
                line_valid <= '0;
            end else if (accept) begin
                for (int b = 0; b < S_BYTES; b++) begin
                    if (s_axi_wstrb[b]) line_valid[word_idx][b] <= 1'b1;
                end
            end

            // Held at zero outside FILL, so it always starts FILL from zero.
            if (accept || (state != FILL))
                idle_cnt <= '0;
            else if (!timeout)
                idle_cnt <= idle_cnt + CNT_W'(1);

            if (state == AW)
                beat <= '0;
            else if ((state == W) && m_axi_wready)
                beat <= beat + BEAT_W'(1);

            if (accept)
                bvalid_q <= 1'b1;
            else if (s_axi_bready)
                bvalid_q <= 1'b0;

            if ((state == B) && m_axi_bvalid && (m_axi_bresp != 2'b00))
                err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line data and base address (no reset: qualified by line_valid/state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            if (state == IDLE)
                base <= {s_axi_awaddr[ADDR_W-1:LINE_LG], {LINE_LG{1'b0}}};
            for (int b = 0; b < S_BYTES; b++) begin
                if (s_axi_wstrb[b])
                    line_data[word_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy          = (state != IDLE);
    assign err           = err_q;

    assign s_axi_awready = accept;
    assign s_axi_wready  = accept;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = base;
    assign m_axi_awlen   = 8'(BL - 1);
    assign m_axi_awsize  = 3'($clog2(M_BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;

    // Beat k carries slave words k*WPB .. k*WPB+WPB-1, lowest word in the
    // lowest lane; bytes never written go out with their strobe low.
    assign m_axi_wdata   = line_data[beat_word +: WPB];
    assign m_axi_wstrb   = line_valid[beat_word +: WPB];
    assign m_axi_wlast   = last_beat;

endmodule
`default_nettype wire

// File: tb/tb_axi_gather_w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_gather_w
//  Description : Self-checking bench for axi_gather_w (default parameters).
//                Directed vector table plus hand-written multi-cycle
//                sequences; a master-side responder/monitor captures bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_gather_w;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         busy, err;
    logic [47:0]  s_axi_awaddr = '0;
    logic         s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b1;
    logic [0:0]   m_axi_awid;
    logic [47:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awlock;
    logic [3:0]   m_axi_awcache;
    logic [2:0]   m_axi_awprot;
    logic [3:0]   m_axi_awqos;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b0;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid;
    logic         m_axi_wready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;

    axi_gather_w dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy), .err(err),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- master-side responder / monitor -----------------
    logic [47:0]  cap_awaddr;
    logic [7:0]   cap_awlen;
    logic [2:0]   cap_awsize;
    logic [1:0]   cap_awburst;
    logic [255:0] cap_data [16];
    logic [31:0]  cap_strb [16];
    logic [15:0]  cap_last;
    int           cap_beats = 16;
    int           aw_count = 0;
    int           burst_done = 0;
    int           stall_at = -1;
    int           stall_left = 0;
    int           stall_seen = 0;
    logic [1:0]   resp_cfg = 2'b00;

    initial begin : responder
        bit b_due = 0;
        bit b_clear = 0;
        bit prev_stall = 0;
        logic [255:0] prev_data;
        logic [31:0]  prev_strb;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_due = 0; b_clear = 0; prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_wvalid_hold", m_axi_wvalid, 1'b1);
                    check("stall_wdata_hold", m_axi_wdata, prev_data);
                    check("stall_wstrb_hold", m_axi_wstrb, prev_strb);
                end
                prev_stall = m_axi_wvalid && !m_axi_wready;
                if (prev_stall) begin
                    stall_seen++;
                    prev_data = m_axi_wdata;
                    prev_strb = m_axi_wstrb;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    cap_awaddr = m_axi_awaddr; cap_awlen = m_axi_awlen;
                    cap_awsize = m_axi_awsize; cap_awburst = m_axi_awburst;
                    cap_beats = 0; cap_last = '0; aw_count++;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (cap_beats < 16) begin
                        cap_data[cap_beats] = m_axi_wdata;
                        cap_strb[cap_beats] = m_axi_wstrb;
                        cap_last[cap_beats] = m_axi_wlast;
                    end
                    cap_beats++;
                    if (m_axi_wlast) b_due = 1;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_clear = 1;
                    burst_done++;
                end
            end
            @(posedge clk); #1;
            m_axi_awready = !rst;
            if (stall_left > 0 && cap_beats == stall_at) begin
                m_axi_wready = 1'b0;
                stall_left--;
            end else begin
                m_axi_wready = !rst;
            end
            if (b_clear) begin m_axi_bvalid = 1'b0; b_clear = 0; end
            if (b_due)   begin m_axi_bvalid = 1'b1; m_axi_bresp = resp_cfg; b_due = 0; end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers -----------------
    task automatic swrite(input logic [47:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int maxc, output int waited);
        logic acc;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (waited = 0; waited < maxc; waited++) begin
            @(negedge clk);
            if (s_axi_awready) break;
            @(posedge clk); #1;
        end
        acc = s_axi_awready;
        check("slave_accept", acc, 1'b1);
        check("slave_joint_ready", s_axi_wready, acc);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (acc) begin
            @(negedge clk);
            check("slave_bvalid_okay", {s_axi_bvalid, s_axi_bresp}, 3'b100);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_burst(input int target, input int maxc);
        for (int i = 0; i < maxc && burst_done < target; i++) begin
            @(posedge clk); #1;
        end
        check("burst_completed", burst_done >= target, 1'b1);
    endtask

    task automatic check_burst(input logic [47:0] a);
        check("awaddr", cap_awaddr, a);
        check("awlen", cap_awlen, 8'd15);
        check("awsize", cap_awsize, 3'd5);
        check("awburst", cap_awburst, 2'd1);
        check("beat_count", cap_beats, 16);
        check("wlast_position", cap_last, 16'h8000);
    endtask

    function automatic logic [255:0] bmask(input logic [31:0] s);
        logic [255:0] m;
        for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    typedef struct {
        logic [47:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic [47:0]  exp_base;
        int           exp_beat;
        logic [31:0]  exp_strb;
        logic [255:0] exp_data;
    } vec_t;

    vec_t tbl [6];

    // ---------------- main sequence -----------------
    initial begin : main
        int w;
        int nb;
        int saved;
        int idx;
        logic [31:0]  others;
        logic [31:0]  all_strb;
        logic [255:0] exp;

        tbl[0] = '{48'h4004, 32'hAABBCCDD, 4'h3, 48'h4000, 0, 32'h0000_0030, 256'h0000CCDD_00000000};
        tbl[1] = '{48'h41FC, 32'h12345678, 4'hF, 48'h4000, 15, 32'hF000_0000, {32'h12345678, 224'h0}};
        tbl[2] = '{48'h5123, 32'hDEADBEEF, 4'h8, 48'h5000, 9, 32'h0000_0008, 256'hDE000000};
        tbl[3] = '{48'h0040, 32'h11223344, 4'h5, 48'h0000, 2, 32'h0000_0005, 256'h00220044};
        tbl[4] = '{48'hFFFF_FFFF_FE18, 32'hCAFEF00D, 4'hF, 48'hFFFF_FFFF_FE00, 0, 32'h0F00_0000,
                   {32'h0, 32'hCAFEF00D, 192'h0}};
        tbl[5] = '{48'h6010, 32'h0000AB00, 4'h2, 48'h6000, 0, 32'h0002_0000, 256'hAB << 136};
        nb = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_s_bvalid", s_axi_bvalid, 1'b0);
        check("rst_m_awvalid", m_axi_awvalid, 1'b0);
        check("rst_m_wvalid", m_axi_wvalid, 1'b0);
        check("rst_m_bready", m_axi_bready, 1'b0);
        check("awcache_const", m_axi_awcache, 4'b0010);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: one write, explicit flush, check placement in the burst
        for (int v = 0; v < 6; v++) begin
            swrite(tbl[v].addr, tbl[v].data, tbl[v].strb, 20, w);
            pulse_flush();
            nb++;
            wait_burst(nb, 200);
            check_burst(tbl[v].exp_base);
            idx = tbl[v].exp_beat;
            check("vec_beat_strb", cap_strb[idx], tbl[v].exp_strb);
            check("vec_beat_data", cap_data[idx] & bmask(cap_strb[idx]), tbl[v].exp_data);
            others = '0;
            for (int k = 0; k < 16; k++) if (k != idx) others |= cap_strb[k];
            check("vec_other_strb", others, 32'h0);
            check("vec_idle_after", busy, 1'b0);
        end

        // Flush while idle does nothing
        saved = aw_count;
        pulse_flush();
        repeat (10) @(posedge clk);
        #1;
        check("idle_flush_no_burst", aw_count, saved);
        check("idle_flush_not_busy", busy, 1'b0);

        // Eight words then idle timeout
        for (int i = 0; i < 8; i++)
            swrite(48'h1000 + 48'(4 * i), 32'h1000_0000 + 32'(i), 4'hF, 20, w);
        saved = aw_count;
        repeat (50) @(posedge clk);
        #1;
        check("no_early_timeout", aw_count, saved);
        nb++;
        wait_burst(nb, 200);
        check_burst(48'h1000);
        check("timeout_beat0_strb", cap_strb[0], 32'hFFFF_FFFF);
        for (int j = 0; j < 8; j++) exp[j*32 +: 32] = 32'h1000_0000 + 32'(j);
        check("timeout_beat0_data", cap_data[0], exp);
        others = '0;
        for (int k = 1; k < 16; k++) others |= cap_strb[k];
        check("timeout_other_strb", others, 32'h0);

        // Full line: flush the cycle after the last merge
        for (int i = 0; i < 128; i++)
            swrite(48'h2000 + 48'(4 * i), 32'h2000_0000 + 32'(i), 4'hF, 20, w);
        check("full_flush_next_cycle", m_axi_awvalid, 1'b1);
        nb++;
        wait_burst(nb, 200);
        check_burst(48'h2000);
        all_strb = '1;
        for (int k = 0; k < 16; k++) all_strb &= cap_strb[k];
        check("full_all_strb", all_strb, 32'hFFFF_FFFF);
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 8; j++) exp[j*32 +: 32] = 32'h2000_0000 + 32'(k * 8 + j);
            check("full_beat_data", cap_data[k], exp);
        end

        // Miss stalls until the current line's burst completes
        swrite(48'h3000, 32'hA5A5A5A5, 4'hF, 20, w);
        swrite(48'h3200, 32'h5A5A5A5A, 4'hF, 200, w);
        nb++;
        check("miss_stalled", w >= 16, 1'b1);
        check("miss_burst_done", burst_done, nb);
        check_burst(48'h3000);
        check("miss_old_strb", cap_strb[0], 32'h0000_000F);
        check("miss_new_line_busy", busy, 1'b1);
        pulse_flush();
        nb++;
        wait_burst(nb, 200);
        check_burst(48'h3200);
        check("miss_new_strb", cap_strb[0], 32'h0000_000F);
        check("miss_new_data", cap_data[0] & bmask(cap_strb[0]), 256'h5A5A5A5A);

        // wready stall mid-burst, SLVERR response, sticky err
        resp_cfg = 2'b10; stall_at = 7; stall_left = 5; stall_seen = 0;
        swrite(48'h70E0, 32'h77777777, 4'hF, 20, w);
        pulse_flush();
        nb++;
        wait_burst(nb, 300);
        check_burst(48'h7000);
        check("stall_cycles", stall_seen, 5);
        check("stall_beat_strb", cap_strb[7], 32'h0000_000F);
        check("stall_beat_data", cap_data[7] & bmask(cap_strb[7]), 256'h77777777);
        check("err_set", err, 1'b1);
        resp_cfg = 2'b00;
        swrite(48'h7200, 32'h1, 4'hF, 20, w);
        pulse_flush();
        nb++;
        wait_burst(nb, 200);
        check("err_sticky", err, 1'b1);

        // Reset in the middle of a burst abandons it
        swrite(48'h8000, 32'h8, 4'hF, 20, w);
        pulse_flush();
        repeat (5) @(posedge clk);
        #1;
        check("midburst_in_w", m_axi_wvalid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_wvalid", m_axi_wvalid, 1'b0);
        check("midrst_awvalid", m_axi_awvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err_clear", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        swrite(48'h9008, 32'h9999, 4'hF, 20, w);
        pulse_flush();
        nb++;
        wait_burst(nb, 200);
        check_burst(48'h9000);
        check("post_rst_strb", cap_strb[0], 32'h0000_0F00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_gather_w.md
AXI_GATHER_W -- requirements
Module: axi_gather_w

Interface
REQ-001 Parameter C_M_AXI_BURST_LEN, default 16, SHALL set the number of beats per master burst.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 48, SHALL set the address width on both ports.
REQ-003 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the slave data width.
REQ-004 Parameter C_M_AXI_DATA_WIDTH, default 256, SHALL set the master data width.
REQ-005 Parameter IDLE_TIMEOUT, default 64, SHALL set the number of idle cycles in FILL before an automatic flush.
REQ-006 clk  in  1  is the single clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-008 flush  in  1  requests write-out of the current line.
REQ-009 busy  out  1  is high when the state is not IDLE.
REQ-010 err  out  1  is a sticky flag set by any non-OKAY master bresp.
REQ-011 Slave write channels: s_axi_awaddr in ADDR, s_axi_awvalid in 1, s_axi_awready out 1.
REQ-012 Slave write data: s_axi_wdata in S_DW, s_axi_wstrb in S_DW/8, s_axi_wvalid in 1, s_axi_wready out 1.
REQ-013 Slave response: s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-014 Master address: m_axi_awaddr out ADDR, m_axi_awlen out 8, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-015 Master data: m_axi_wdata out M_DW, m_axi_wstrb out M_DW/8, m_axi_wlast out 1, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-016 Master response: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-017 Constant outputs: m_axi_awid=0, m_axi_awlock=0, m_axi_awcache=4'b0010, m_axi_awprot=0, m_axi_awqos=0.

Function
REQ-018 The line size SHALL be LINE=BURST_LEN*M_DW/8 bytes (512 by default), and the line base SHALL be the address with its low log2(LINE) bits cleared.
REQ-019 The FSM SHALL have the states IDLE, FILL, AW, W and B.
REQ-020 The slave handshake SHALL be joint: s_axi_awready and s_axi_wready SHALL be high together, in IDLE or FILL only, with s_axi_bvalid low, when both valids are high and the address is acceptable.
REQ-021 In IDLE any address SHALL be acceptable; the accept SHALL latch the line base and go to FILL. In FILL only addresses that hit the current line SHALL be acceptable.
REQ-022 On accept, the bytes enabled by s_axi_wstrb SHALL be merged into buffer word (addr-base)>>2, with matching byte-valid bits set; addr[1:0] SHALL be ignored; a repeat write SHALL overwrite bytes.
REQ-023 s_axi_bvalid SHALL rise the cycle after accept, with s_axi_bresp=OKAY, and SHALL hold until s_axi_bready.
REQ-024 From FILL, the block SHALL go to AW (flush) on any of: a miss with both slave valids high; all byte-valid bits set, in the cycle after the last merge; flush=1; or the idle counter reaching IDLE_TIMEOUT. Simultaneous triggers SHALL cause exactly one flush.
REQ-025 The idle counter SHALL reset on every accept and on FILL entry; flush=1 in IDLE SHALL be ignored.
REQ-026 In AW: m_axi_awaddr=base, m_axi_awlen=BURST_LEN-1, m_axi_awsize=log2(M_DW/8), m_axi_awburst=INCR; m_axi_awvalid SHALL hold until m_axi_awready, then go to W.
REQ-027 In W, beat k SHALL carry buffer words k*M_DW/S_DW upward, with m_axi_wstrb set to their byte-valid bits (all-zero allowed) and m_axi_wlast on k=BURST_LEN-1; m_axi_wvalid SHALL hold each beat until m_axi_wready.
REQ-028 In B, m_axi_bready SHALL be 1; on m_axi_bvalid, err SHALL |= (bresp!=0), the valid map SHALL clear, and the state SHALL go to IDLE. A pending missed request SHALL then be accepted from IDLE.
REQ-029 The master and slave sides SHALL never merge and drain at the same time; the buffer is single-line.

Reset
REQ-030 With rst=1 at a clk edge: state IDLE; every valid/ready output 0 except m_axi_bready=0; err=0; valid map cleared; idle counter 0; buffer data not reset.
REQ-031 Reset mid-burst SHALL abandon the burst; the interconnect SHALL be reset together with the block.

Verification
REQ-032 8 sequential writes to 0x1000..0x101C with wstrb=F, then 64 idle cycles -> one burst at awaddr 0x1000 with awlen=15; beat 0 wstrb=0xFFFFFFFF; beats 1-15 wstrb=0.
REQ-033 128 writes covering 0x2000..0x21FC -> flush the cycle after the last merge; 16 beats with all strobes set; wlast on beat 15.
REQ-034 Write 0x3000, then write 0x3200 -> 0x3200 stalled (awready=0) until the 0x3000 burst B completes, then accepted and placed in a new line.
REQ-035 Write 0x4004 with wstrb=0x3, then flush=1 -> beat 0 wstrb=0x00000030; flush=1 while IDLE -> no burst.
REQ-036 m_axi_wready held low 5 cycles mid-burst, then bresp=SLVERR -> data stable throughout the stall, err=1 sticky until rst.
